wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Registered, parametrised writeback stage for the 16-bit core; sits after the memory stage and drives the register-file write port.
- Selects the write data from one of four sources: ALU result, rs read data, memory load data, extended immediate.
- Unlike the combinational predecessor, it tolerates variable-latency memory read responses. It holds the pipeline with a valid/ready handshake, buffers one early response, and flags timeouts.

Parameters:
DATA_W, 16, datapath and register width
REG_ADDR_W, 3, register-file address width
MEM_TIMEOUT, 15, max wait cycles for a load response; 0 = no timeout

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage can accept; handshake fires when in_valid && in_ready
in_regwrite  in  1  instruction writes a register
in_rd  in  REG_ADDR_W  destination register
in_sel  in  2  source: 0 ALU, 1 rd1, 2 memory, 3 ext_imm
in_alu  in  DATA_W  ALU result
in_rd1  in  DATA_W  register read data
in_ext  in  DATA_W  extended immediate
mem_rvalid  in  1  memory read data valid (single-cycle pulse per response)
mem_rdata  in  DATA_W  memory read data
rf_we  out  1  register-file write enable (registered)
rf_waddr  out  REG_ADDR_W  write address (registered)
rf_wdata  out  DATA_W  write data (registered)
err_overflow  out  1  sticky: response dropped, buffer full
err_timeout  out  1  sticky: load abandoned after MEM_TIMEOUT

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. rst_n low clears all state.
- Reset values: FSM=IDLE, in_ready=1, rf_we=0, rf_waddr=0, rf_wdata=0, buffer empty, counter=0, both error flags 0. Reset mid-wait abandons the load with no write.
- FSM states:
  - IDLE: in_ready=1.
  - WAIT_MEM: in_ready=0.
- Non-load accept (in_sel != 2): next cycle rf_we=in_regwrite, rf_waddr=in_rd, rf_wdata=selected source. Latency 1. Back-to-back accepts give one write per cycle.
- rf_we is a 1-cycle pulse per write. rf_waddr and rf_wdata hold their values when rf_we=0.
- Load accept (in_sel==2), data source priority:
  - (a) Buffer full: consume the buffer.
  - (b) Else mem_rvalid this cycle: use mem_rdata directly.
  - (c) Else go to WAIT_MEM, latch rd/regwrite, clear the counter.
  - For (a) and (b): write next cycle and stay in IDLE.
- WAIT_MEM:
  - On mem_rvalid: write mem_rdata next cycle (rf_we=latched regwrite) and return to IDLE. in_ready=1 in the same cycle rf_we is asserted.
  - Otherwise the counter increments. If MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT: set err_timeout, no write, return to IDLE.
- A load with in_regwrite=0 still consumes exactly one response.
- Early-response buffer (1 entry): mem_rvalid in IDLE with no load accepted that cycle stores mem_rdata.
- Buffer full and a load accepted with mem_rvalid in the same cycle: the buffer is consumed and the new data refills it, so it stays full.
- Buffer full, mem_rvalid, and no load accepted: data dropped, err_overflow set.
- Error flags clear only on reset.
- No hardwired-zero register: every address is writable.

Optional Feature:
- Macro: WB_FWD_EN.
- Defined: adds outputs fwd_valid (1), fwd_addr (REG_ADDR_W), fwd_data (DATA_W).
  - These are the combinational next-cycle write (value to be written on the coming edge) for decode-stage bypass.
  - fwd_valid=0 in WAIT_MEM until mem_rvalid.
- Undefined: ports absent; behaviour otherwise identical.

Decomposition:
- Shared package core_pkg holds:
  - wb_sel_e enum: WB_ALU=0, WB_RD1=1, WB_MEM=2, WB_EXT=3.
  - wb_state_e enum: IDLE, WAIT_MEM.
  - DATA_W default constant.
- One sub-module is natural: wb_resp_buf, the 1-entry response buffer with push, pop and overflow logic.

Test Plan:
- Reset, then accept sel=0 alu=16'h1234 rd=3 regwrite=1 -> next cycle rf_we=1, waddr=3, wdata=16'h1234; all other reset values as specified.
- Load sel=2 rd=5, mem_rvalid 3 cycles later with 16'hBEEF -> in_ready=0 for 3 cycles; rf_we=1 waddr=5 wdata=16'hBEEF on the cycle after rvalid.
- mem_rvalid 16'h00AA in IDLE, then load rd=2 two cycles later -> write 16'h00AA to r2 one cycle after accept, with no stall.
- Buffer full, second idle rvalid 16'h5555 -> err_overflow=1; next load writes the first buffered value.
- MEM_TIMEOUT=4, load with no response -> err_timeout=1 after 4 wait cycles, no rf_we, in_ready returns to 1.
- Reset asserted during WAIT_MEM -> outputs return to reset values immediately; a late rvalid is buffered, not written.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the 16-bit core pipeline.
//   wb_sel_e    : writeback source select encoding
//   wb_state_e  : writeback stage FSM states
//   CORE_DATA_W : default datapath width
package core_pkg;

  localparam int CORE_DATA_W = 16;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_RD1 = 2'd1,
    WB_MEM = 2'd2,
    WB_EXT = 2'd3
  } wb_sel_e;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_resp_buf.sv
// One-entry buffer for memory read responses that arrive before their load.
//   push/din  : store a response (ignored with overflow flagged if full and not popped)
//   pop       : consume the stored response
//   full/dout : buffer occupancy and stored data
//   overflow  : sticky, a response was dropped; cleared only by reset
module wb_resp_buf #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic              full,
  output logic [DATA_W-1:0] dout,
  output logic              overflow
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full     <= 1'b0;
      dout     <= '0;
      overflow <= 1'b0;
    end else begin
      // pop and push together refill the entry, so it stays full
      if (push && (!full || pop)) begin
        full <= 1'b1;
        dout <= din;
      end else if (pop) begin
        full <= 1'b0;
      end
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Registered writeback stage: selects ALU / rs / load / immediate data and
// drives the register-file write port one cycle after accept. Loads may wait
// for a variable-latency memory response (WAIT_MEM, in_ready low); a response
// arriving while idle is held in a one-entry buffer for the next load.
// Ports:
//   in_valid/in_ready       : upstream handshake
//   in_regwrite, in_rd      : destination control
//   in_sel                  : 0 ALU, 1 rd1, 2 memory, 3 ext_imm
//   in_alu, in_rd1, in_ext  : candidate write data
//   mem_rvalid, mem_rdata   : memory read response (one-cycle pulse)
//   rf_we/rf_waddr/rf_wdata : registered register-file write port
//   err_overflow            : sticky, early response dropped (buffer full)
//   err_timeout             : sticky, load abandoned after MEM_TIMEOUT waits
// Optional macro WB_FWD_EN adds fwd_valid/fwd_addr/fwd_data: the write that
// will be registered on the coming edge, for decode-stage bypass.
module wb_stage
  import core_pkg::*;
#(
  parameter int DATA_W      = CORE_DATA_W,
  parameter int REG_ADDR_W  = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_regwrite,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [1:0]            in_sel,
  input  logic [DATA_W-1:0]     in_alu,
  input  logic [DATA_W-1:0]     in_rd1,
  input  logic [DATA_W-1:0]     in_ext,
  input  logic                  mem_rvalid,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic                  err_overflow,
  output logic                  err_timeout
`ifdef WB_FWD_EN
  ,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0]     fwd_data
`endif
);

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  wb_state_e             state, state_nxt;
  wb_sel_e               sel;
  logic                  accept, load_acc, load_stall, timeout_hit;
  logic                  buf_full, buf_push, buf_pop;
  logic [DATA_W-1:0]     buf_data, src_data;
  logic [CNT_W-1:0]      cnt, cnt_inc;
  logic                  pend_we;
  logic [REG_ADDR_W-1:0] pend_rd;
  logic                  we_nxt;
  logic [REG_ADDR_W-1:0] waddr_nxt;
  logic [DATA_W-1:0]     wdata_nxt;

  assign sel        = wb_sel_e'(in_sel);
  assign in_ready   = (state == IDLE);
  assign accept     = in_valid && in_ready;
  assign load_acc   = accept && (sel == WB_MEM);
  // load with no data available yet: buffer empty and no response this cycle
  assign load_stall = load_acc && !buf_full && !mem_rvalid;
  assign cnt_inc    = cnt + 1'b1;
  assign timeout_hit = (MEM_TIMEOUT > 0) && (cnt_inc == CNT_W'(MEM_TIMEOUT));

  // buffered response takes priority over a same-cycle response
  always_comb begin
    src_data = in_alu;
    case (sel)
      WB_ALU:  src_data = in_alu;
      WB_RD1:  src_data = in_rd1;
      WB_MEM:  src_data = buf_full ? buf_data : mem_rdata;
      WB_EXT:  src_data = in_ext;
      default: src_data = in_alu;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (load_stall) state_nxt = WAIT_MEM;
      WAIT_MEM: if (mem_rvalid || timeout_hit) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // outputs: next write and buffer control
  always_comb begin
    we_nxt    = 1'b0;
    waddr_nxt = rf_waddr;
    wdata_nxt = rf_wdata;
    buf_push  = 1'b0;
    buf_pop   = 1'b0;
    case (state)
      IDLE: begin
        buf_pop  = load_acc && buf_full;
        // an idle response is stored unless a load uses it directly
        buf_push = mem_rvalid && !(load_acc && !buf_full);
        if (accept && !load_stall) begin
          we_nxt = in_regwrite;
          if (in_regwrite) begin
            waddr_nxt = in_rd;
            wdata_nxt = src_data;
          end
        end
      end
      WAIT_MEM: begin
        if (mem_rvalid) begin
          we_nxt = pend_we;
          if (pend_we) begin
            waddr_nxt = pend_rd;
            wdata_nxt = mem_rdata;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we       <= 1'b0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
      cnt         <= '0;
      pend_we     <= 1'b0;
      pend_rd     <= '0;
      err_timeout <= 1'b0;
    end else begin
      rf_we    <= we_nxt;
      rf_waddr <= waddr_nxt;
      rf_wdata <= wdata_nxt;
      if (state == IDLE) begin
        cnt <= '0;
        if (load_acc) begin
          pend_we <= in_regwrite;
          pend_rd <= in_rd;
        end
      end else if (!mem_rvalid) begin
        cnt <= cnt_inc;
        if (timeout_hit) err_timeout <= 1'b1;
      end
    end
  end

  wb_resp_buf #(.DATA_W(DATA_W)) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (buf_push),
    .pop      (buf_pop),
    .din      (mem_rdata),
    .full     (buf_full),
    .dout     (buf_data),
    .overflow (err_overflow)
  );

`ifdef WB_FWD_EN
  assign fwd_valid = we_nxt;
  assign fwd_addr  = waddr_nxt;
  assign fwd_data  = wdata_nxt;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage (MEM_TIMEOUT=4). Stimulus pushes expected
// register writes into a scoreboard queue; a negedge monitor pops and
// compares on every rf_we. Handshake/flag timing is checked inline.
module tb_wb_stage;

  typedef struct packed {
    logic [2:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic        clk, rst_n;
  logic        in_valid, in_ready, in_regwrite;
  logic [2:0]  in_rd;
  logic [1:0]  in_sel;
  logic [15:0] in_alu, in_rd1, in_ext;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        err_overflow, err_timeout;
`ifdef WB_FWD_EN
  logic        fwd_valid;
  logic [2:0]  fwd_addr;
  logic [15:0] fwd_data;
`endif

  wr_t sb[$];
  int  n_vec = 0;
  int  n_err = 0;

  wb_stage #(.DATA_W(16), .REG_ADDR_W(3), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_regwrite(in_regwrite),
    .in_rd(in_rd), .in_sel(in_sel), .in_alu(in_alu), .in_rd1(in_rd1),
    .in_ext(in_ext), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .err_overflow(err_overflow), .err_timeout(err_timeout)
`ifdef WB_FWD_EN
    , .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && rf_we) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got addr %0d data %h, expected no write", rf_waddr, rf_wdata);
      end else begin
        wr_t e;
        e = sb.pop_front();
        if (rf_waddr !== e.addr || rf_wdata !== e.data) begin
          n_err++;
          $display("FAIL write: got addr %0d data %h, expected addr %0d data %h",
                   rf_waddr, rf_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expw(input logic [2:0] a, input logic [15:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  // one cycle of stimulus; unselected sources carry junk so the mux is exercised
  task automatic op(input logic v, input logic rw, input logic [2:0] rd, input logic [1:0] s,
                    input logic [15:0] val, input logic rv, input logic [15:0] rdat);
    in_valid    = v;
    in_regwrite = rw;
    in_rd       = rd;
    in_sel      = s;
    in_alu      = (s == 2'd0) ? val : 16'hDEAD;
    in_rd1      = (s == 2'd1) ? val : 16'hBAD1;
    in_ext      = (s == 2'd3) ? val : 16'hE0E0;
    mem_rvalid  = rv;
    mem_rdata   = rv ? rdat : 16'hFACE;
    tick();
    in_valid   = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_regwrite = 1'b0; in_rd = '0; in_sel = '0;
    in_alu = '0; in_rd1 = '0; in_ext = '0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_err_ov", err_overflow, 0);
    chk("rst_err_to", err_timeout, 0);
    rst_n = 1'b1;
    tick();

    // ALU write, latency 1
    expw(3'd3, 16'h1234);
    op(1, 1, 3'd3, 2'd0, 16'h1234, 0, 0);
    chk("alu_we", rf_we, 1);
    tick();
    chk("we_pulse", rf_we, 0);

    // back-to-back: ext_imm to r0 (writable), then rd1
    expw(3'd0, 16'h7E57);
    op(1, 1, 3'd0, 2'd3, 16'h7E57, 0, 0);
    chk("b2b_we0", rf_we, 1);
    expw(3'd4, 16'h00C3);
    op(1, 1, 3'd4, 2'd1, 16'h00C3, 0, 0);
    chk("b2b_we1", rf_we, 1);

    // regwrite=0: no write, address/data hold
    op(1, 0, 3'd7, 2'd0, 16'hFFFF, 0, 0);
    chk("nowr_we", rf_we, 0);
    chk("nowr_waddr", rf_waddr, 4);
    chk("nowr_wdata", rf_wdata, 16'h00C3);

    // load with response in the accept cycle
    expw(3'd6, 16'h0B0B);
    op(1, 1, 3'd6, 2'd2, 0, 1, 16'h0B0B);
    chk("ld_direct_we", rf_we, 1);
    chk("ld_direct_rdy", in_ready, 1);

    // load waiting 3 cycles for its response
    expw(3'd5, 16'hBEEF);
    op(1, 1, 3'd5, 2'd2, 0, 0, 0);
    chk("ld_wait_rdy1", in_ready, 0);
    tick();
    chk("ld_wait_rdy2", in_ready, 0);
    tick();
    chk("ld_wait_rdy3", in_ready, 0);
    op(0, 0, 0, 0, 0, 1, 16'hBEEF);
    chk("ld_wait_we", rf_we, 1);
    chk("ld_wait_rdy", in_ready, 1);

    // early response buffered, consumed without a stall
    op(0, 0, 0, 0, 0, 1, 16'h00AA);
    tick();
    expw(3'd2, 16'h00AA);
    op(1, 1, 3'd2, 2'd2, 0, 0, 0);
    chk("early_we", rf_we, 1);
    chk("early_rdy", in_ready, 1);

    // overflow: second idle response dropped, first one kept
    op(0, 0, 0, 0, 0, 1, 16'h1111);
    chk("ovf_before", err_overflow, 0);
    op(0, 0, 0, 0, 0, 1, 16'h5555);
    chk("ovf_set", err_overflow, 1);
    expw(3'd6, 16'h1111);
    op(1, 1, 3'd6, 2'd2, 0, 0, 0);
    chk("ovf_ld_rdy", in_ready, 1);

    // full buffer + load + response: consume and refill
    op(0, 0, 0, 0, 0, 1, 16'h2222);
    expw(3'd1, 16'h2222);
    op(1, 1, 3'd1, 2'd2, 0, 1, 16'h3333);
    expw(3'd4, 16'h3333);
    op(1, 1, 3'd4, 2'd2, 0, 0, 0);
    chk("refill_we", rf_we, 1);
    chk("refill_rdy", in_ready, 1);

    // load with regwrite=0 still consumes one response
    op(1, 0, 3'd7, 2'd2, 0, 0, 0);
    chk("nowr_ld_rdy0", in_ready, 0);
    op(0, 0, 0, 0, 0, 1, 16'h9999);
    chk("nowr_ld_we", rf_we, 0);
    chk("nowr_ld_rdy1", in_ready, 1);

    // timeout after 4 wait cycles (buffer must be empty here)
    op(1, 1, 3'd7, 2'd2, 0, 0, 0);
    chk("to_rdy0", in_ready, 0);
    tick();
    tick();
    tick();
    chk("to_rdy3", in_ready, 0);
    chk("to_flag3", err_timeout, 0);
    tick();
    chk("to_flag4", err_timeout, 1);
    chk("to_rdy4", in_ready, 1);
    chk("to_we", rf_we, 0);

    // reset during WAIT_MEM
    op(1, 1, 3'd3, 2'd2, 0, 0, 0);
    chk("rw_rdy0", in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("rw_rdy", in_ready, 1);
    chk("rw_we", rf_we, 0);
    chk("rw_waddr", rf_waddr, 0);
    chk("rw_wdata", rf_wdata, 0);
    chk("rw_err_to", err_timeout, 0);
    chk("rw_err_ov", err_overflow, 0);
    tick();
    rst_n = 1'b1;
    op(0, 0, 0, 0, 0, 1, 16'hABCD);
    chk("late_rv_we", rf_we, 0);
    expw(3'd2, 16'hABCD);
    op(1, 1, 3'd2, 2'd2, 0, 0, 0);
    chk("late_ld_we", rf_we, 1);

    tick();
    tick();
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
